// File: rtl/div_sched.sv
// Round-robin scheduler sharing one long divider between NREQ requesters.
// Optional DIV_ZERO_CHECK_EN: zero divisors bypass the divider and return q=all ones, r=dividend, resp_err=1.
module div_sched #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_dividend,
    input  logic [NREQ*WIDTH-1:0]   req_divisor,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         resp_valid,
    output logic [WIDTH-1:0]        resp_q,
    output logic [WIDTH-1:0]        resp_r,
    output logic                    resp_err,
    output logic                    busy,
    output logic [WIDTH-1:0]        div_dividend,
    output logic [WIDTH-1:0]        div_divisor,
    output logic                    div_start,
    input  logic [WIDTH-1:0]        div_q,
    input  logic [WIDTH-1:0]        div_r,
    input  logic                    div_valid
);

    // state   | meaning
    // IDLE    | arbitrate pending requests
    // GRANT   | gnt pulse, operands latched into divider inputs
    // RUN     | div_start held, waiting for div_valid
    // DONE    | resp_valid pulse, div_start low so the divider clears
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    win;
    logic [PW-1:0]    arb_idx;
    logic [PW-1:0]    hi_idx;
    logic             arb_hit;
    logic             hi_hit;
    logic [NREQ-1:0]  arb_onehot;
    logic [NREQ-1:0]  win_onehot;
    logic [WIDTH-1:0] sel_dividend;
    logic [WIDTH-1:0] sel_divisor;

    // Lowest requester above rr_ptr wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        hi_hit  = 1'b0;
        hi_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && (PW'(i) > rr_ptr) && !hi_hit) begin
                hi_hit = 1'b1;
                hi_idx = PW'(i);
            end
            if (req[i] && !arb_hit) begin
                arb_hit = 1'b1;
                arb_idx = PW'(i);
            end
        end
        if (hi_hit) begin
            arb_idx = hi_idx;
        end
    end

    always_comb begin
        arb_onehot   = '0;
        win_onehot   = '0;
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int i = 0; i < NREQ; i++) begin
            arb_onehot[i] = (arb_idx == PW'(i));
            win_onehot[i] = (win == PW'(i));
            if (win == PW'(i)) begin
                sel_dividend = req_dividend[i*WIDTH +: WIDTH];
                sel_divisor  = req_divisor[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef DIV_ZERO_CHECK_EN
    logic err_pend;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            rr_ptr       <= PW'(NREQ - 1);
            win          <= '0;
            gnt          <= '0;
            resp_valid   <= '0;
            resp_q       <= '0;
            resp_r       <= '0;
            busy         <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            div_start    <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
            resp_err     <= 1'b0;
            err_pend     <= 1'b0;
`endif
        end else begin
            gnt        <= '0;
            resp_valid <= '0;
`ifdef DIV_ZERO_CHECK_EN
            resp_err   <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (arb_hit) begin
                        win   <= arb_idx;
                        gnt   <= arb_onehot;
                        busy  <= 1'b1;
                        state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    rr_ptr       <= win;
                    div_dividend <= sel_dividend;
                    div_divisor  <= sel_divisor;
`ifdef DIV_ZERO_CHECK_EN
                    if (sel_divisor == '0) begin
                        resp_q   <= '1;
                        resp_r   <= sel_dividend;
                        err_pend <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        div_start <= 1'b1;
                        state     <= S_RUN;
                    end
`else
                    div_start <= 1'b1;
                    state     <= S_RUN;
`endif
                end
                S_RUN: begin
                    if (div_valid) begin
                        resp_q     <= div_q;
                        resp_r     <= div_r;
                        div_start  <= 1'b0;
                        resp_valid <= win_onehot;
                        state      <= S_DONE;
                    end
                end
                default: begin
`ifdef DIV_ZERO_CHECK_EN
                    // Zero-divisor path spends one quiet DONE cycle so the pulse lands two cycles after gnt.
                    if (err_pend) begin
                        err_pend   <= 1'b0;
                        resp_valid <= win_onehot;
                        resp_err   <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
`else
                    busy  <= 1'b0;
                    state <= S_IDLE;
`endif
                end
            endcase
        end
    end

endmodule
